// File: rtl/bp_axi_dma_gearbox.sv
// Multi-channel bidirectional gearbox between L2 DMA fill-width words and AXI beats.
// Read lanes assemble beats into fill words; write lanes serialise fill words into beats.

module bp_axi_dma_gearbox_rd_lane #(
   parameter int aw_p    = 64,
   parameter int ratio_p = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [aw_p-1:0]         axi_data_i,
   input  logic                    axi_last_i,
   input  logic                    axi_v_i,
   output logic                    axi_ready_and_o,
   output logic [ratio_p*aw_p-1:0] fill_data_o,
   output logic                    fill_v_o,
   input  logic                    fill_ready_and_i,
   output logic                    err_o,
   input  logic                    err_clr_i
);
   localparam int cw_lp = (ratio_p > 1) ? $clog2(ratio_p) : 1;
   localparam bit multi_lp = (ratio_p > 1);

   typedef enum logic {e_fill, e_full} rd_state_e;

   rd_state_e                     state_r, state_n;
   logic [cw_lp-1:0]              cnt_r, cnt_n, wr_idx;
   logic [ratio_p-1:0][aw_p-1:0]  data_r, data_n;
   logic                          err_r, err_n, err_set, last_slot, fire, acc;

   assign fill_v_o        = (state_r == e_full);
   // Flow-through: a held word may be consumed in the same cycle the next beat 0 lands
   assign axi_ready_and_o = reset_n_i & ((state_r == e_fill) | fill_ready_and_i);
   assign fire            = fill_v_o & fill_ready_and_i;
   assign acc             = axi_v_i & axi_ready_and_o;
   assign wr_idx          = (state_r == e_full) ? '0 : cnt_r;
   assign last_slot       = (wr_idx == cw_lp'(ratio_p-1));
   assign fill_data_o     = data_r;
   assign err_o           = err_r;

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      data_n  = data_r;
      err_set = 1'b0;
      if (fire) begin
         state_n = e_fill;
         cnt_n   = '0;
      end
      if (acc) begin
         // Clearing on beat 0 leaves the unwritten tail of a short burst at zero
         if (wr_idx == '0) data_n = '0;
         data_n[wr_idx] = axi_data_i;
         if (last_slot | axi_last_i) begin
            state_n = e_full;
            cnt_n   = '0;
            err_set = multi_lp & (last_slot ^ axi_last_i);
         end else begin
            state_n = e_fill;
            cnt_n   = wr_idx + 1'b1;
         end
      end
      err_n = err_set | (err_r & ~err_clr_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_fill;
         cnt_r   <= '0;
         data_r  <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         data_r  <= data_n;
         err_r   <= err_n;
      end
   end
endmodule

module bp_axi_dma_gearbox_wr_lane #(
   parameter int aw_p    = 64,
   parameter int ratio_p = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [ratio_p*aw_p-1:0] fill_data_i,
   input  logic                    fill_v_i,
   output logic                    fill_ready_and_o,
   output logic [aw_p-1:0]         axi_data_o,
   output logic                    axi_last_o,
   output logic                    axi_v_o,
   input  logic                    axi_ready_and_i
);
   localparam int cw_lp = (ratio_p > 1) ? $clog2(ratio_p) : 1;

   typedef enum logic {e_idle, e_send} wr_state_e;

   wr_state_e                     state_r, state_n;
   logic [cw_lp-1:0]              cnt_r, cnt_n;
   logic [ratio_p-1:0][aw_p-1:0]  word_r, word_n;
   logic                          last_beat, beat_acc, word_acc;

   assign last_beat        = (cnt_r == cw_lp'(ratio_p-1));
   assign axi_v_o          = (state_r == e_send);
   assign axi_data_o       = word_r[cnt_r];
   assign axi_last_o       = axi_v_o & last_beat;
   // Taking the next word while the last beat drains avoids a bubble between words
   assign fill_ready_and_o = reset_n_i & ((state_r == e_idle) | (axi_ready_and_i & last_beat));
   assign beat_acc         = axi_v_o & axi_ready_and_i;
   assign word_acc         = fill_v_i & fill_ready_and_o;

   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      word_n  = word_r;
      if (beat_acc) begin
         if (last_beat) begin
            state_n = e_idle;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt_r + 1'b1;
         end
      end
      if (word_acc) begin
         state_n = e_send;
         cnt_n   = '0;
         word_n  = fill_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_idle;
         cnt_r   <= '0;
         word_r  <= '0;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         word_r  <= word_n;
      end
   end
endmodule

module bp_axi_dma_gearbox #(
   parameter int fill_width_p     = 512,
   parameter int axi_data_width_p = 64,
   parameter int num_ch_p         = 2
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic [num_ch_p*axi_data_width_p-1:0] rd_axi_data_i,
   input  logic [num_ch_p-1:0]                rd_axi_last_i,
   input  logic [num_ch_p-1:0]                rd_axi_v_i,
   output logic [num_ch_p-1:0]                rd_axi_ready_and_o,
   output logic [num_ch_p*fill_width_p-1:0]   rd_fill_data_o,
   output logic [num_ch_p-1:0]                rd_fill_v_o,
   input  logic [num_ch_p-1:0]                rd_fill_ready_and_i,
   input  logic [num_ch_p*fill_width_p-1:0]   wr_fill_data_i,
   input  logic [num_ch_p-1:0]                wr_fill_v_i,
   output logic [num_ch_p-1:0]                wr_fill_ready_and_o,
   output logic [num_ch_p*axi_data_width_p-1:0] wr_axi_data_o,
   output logic [num_ch_p-1:0]                wr_axi_last_o,
   output logic [num_ch_p-1:0]                wr_axi_v_o,
   input  logic [num_ch_p-1:0]                wr_axi_ready_and_i,
   output logic [num_ch_p-1:0]                rd_err_o,
   input  logic [num_ch_p-1:0]                err_clr_i
);
   localparam int ratio_lp = fill_width_p / axi_data_width_p;

   if ((ratio_lp < 1) || (fill_width_p != ratio_lp*axi_data_width_p)
       || ((ratio_lp & (ratio_lp-1)) != 0)) begin : g_bad_ratio
      $error("fill_width_p/axi_data_width_p must be a power of two >= 1");
   end

   logic [num_ch_p-1:0][axi_data_width_p-1:0] rd_axi_data, wr_axi_data;
   logic [num_ch_p-1:0][fill_width_p-1:0]     rd_fill_data, wr_fill_data;

   assign rd_axi_data    = rd_axi_data_i;
   assign wr_fill_data   = wr_fill_data_i;
   assign rd_fill_data_o = rd_fill_data;
   assign wr_axi_data_o  = wr_axi_data;

   for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
      bp_axi_dma_gearbox_rd_lane #(.aw_p(axi_data_width_p), .ratio_p(ratio_lp)) u_rd (
         .clk_i            (clk_i),
         .reset_n_i        (reset_n_i),
         .axi_data_i       (rd_axi_data[c]),
         .axi_last_i       (rd_axi_last_i[c]),
         .axi_v_i          (rd_axi_v_i[c]),
         .axi_ready_and_o  (rd_axi_ready_and_o[c]),
         .fill_data_o      (rd_fill_data[c]),
         .fill_v_o         (rd_fill_v_o[c]),
         .fill_ready_and_i (rd_fill_ready_and_i[c]),
         .err_o            (rd_err_o[c]),
         .err_clr_i        (err_clr_i[c])
      );
      bp_axi_dma_gearbox_wr_lane #(.aw_p(axi_data_width_p), .ratio_p(ratio_lp)) u_wr (
         .clk_i            (clk_i),
         .reset_n_i        (reset_n_i),
         .fill_data_i      (wr_fill_data[c]),
         .fill_v_i         (wr_fill_v_i[c]),
         .fill_ready_and_o (wr_fill_ready_and_o[c]),
         .axi_data_o       (wr_axi_data[c]),
         .axi_last_o       (wr_axi_last_o[c]),
         .axi_v_o          (wr_axi_v_o[c]),
         .axi_ready_and_i  (wr_axi_ready_and_i[c])
      );
   end
endmodule

// File: tb/tb_bp_axi_dma_gearbox.sv
// Bench for bp_axi_dma_gearbox: queue-based transaction model checked every cycle,
// plus directed sequences with literal expectations.

module tb_bp_axi_dma_gearbox;
   localparam int FW = 256;
   localparam int AW = 64;
   localparam int NC = 2;
   localparam int R  = FW / AW;

   logic clk = 1'b0;
   logic reset_n;
   logic [NC-1:0][AW-1:0] rd_axi_data;
   logic [NC-1:0]         rd_axi_last, rd_axi_v, rd_axi_ready;
   logic [NC-1:0][FW-1:0] rd_fill_data;
   logic [NC-1:0]         rd_fill_v, rd_fill_ready;
   logic [NC-1:0][FW-1:0] wr_fill_data;
   logic [NC-1:0]         wr_fill_v, wr_fill_ready;
   logic [NC-1:0][AW-1:0] wr_axi_data;
   logic [NC-1:0]         wr_axi_last, wr_axi_v, wr_axi_ready;
   logic [NC-1:0]         rd_err, err_clr;

   bp_axi_dma_gearbox #(.fill_width_p(FW), .axi_data_width_p(AW), .num_ch_p(NC)) dut (
      .clk_i               (clk),
      .reset_n_i           (reset_n),
      .rd_axi_data_i       (rd_axi_data),
      .rd_axi_last_i       (rd_axi_last),
      .rd_axi_v_i          (rd_axi_v),
      .rd_axi_ready_and_o  (rd_axi_ready),
      .rd_fill_data_o      (rd_fill_data),
      .rd_fill_v_o         (rd_fill_v),
      .rd_fill_ready_and_i (rd_fill_ready),
      .wr_fill_data_i      (wr_fill_data),
      .wr_fill_v_i         (wr_fill_v),
      .wr_fill_ready_and_o (wr_fill_ready),
      .wr_axi_data_o       (wr_axi_data),
      .wr_axi_last_o       (wr_axi_last),
      .wr_axi_v_o          (wr_axi_v),
      .wr_axi_ready_and_i  (wr_axi_ready),
      .rd_err_o            (rd_err),
      .err_clr_i           (err_clr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      logic [AW-1:0] d;
      bit            last;
   } beat_t;

   logic [AW-1:0] m_beats [NC][$];
   beat_t         m_wq    [NC][$];
   bit            m_full  [NC];
   logic [FW-1:0] m_word  [NC];
   bit            m_err   [NC];

   always @(negedge clk) begin : cmp
      bit e_rrdy, e_wrdy, fire, acc, bacc, wacc;
      logic [FW-1:0] w;
      beat_t b;
      for (int c = 0; c < NC; c++) begin
         if (!reset_n) begin
            chk($sformatf("rst_rd_axi_ready[%0d]", c), rd_axi_ready[c], 0);
            chk($sformatf("rst_wr_fill_ready[%0d]", c), wr_fill_ready[c], 0);
            chk($sformatf("rst_rd_fill_v[%0d]", c), rd_fill_v[c], 0);
            chk($sformatf("rst_wr_axi_v[%0d]", c), wr_axi_v[c], 0);
            chk($sformatf("rst_rd_err[%0d]", c), rd_err[c], 0);
            m_full[c] = 0;
            m_err[c]  = 0;
            m_beats[c].delete();
            m_wq[c].delete();
         end else begin
            e_rrdy = !m_full[c] || rd_fill_ready[c];
            e_wrdy = (m_wq[c].size() == 0) || (m_wq[c].size() == 1 && wr_axi_ready[c]);
            chk($sformatf("rd_axi_ready[%0d]", c), rd_axi_ready[c], e_rrdy);
            chk($sformatf("rd_fill_v[%0d]", c), rd_fill_v[c], m_full[c]);
            if (m_full[c]) chk($sformatf("rd_fill_data[%0d]", c), rd_fill_data[c], m_word[c]);
            chk($sformatf("rd_err[%0d]", c), rd_err[c], m_err[c]);
            chk($sformatf("wr_fill_ready[%0d]", c), wr_fill_ready[c], e_wrdy);
            chk($sformatf("wr_axi_v[%0d]", c), wr_axi_v[c], m_wq[c].size() > 0);
            if (m_wq[c].size() > 0) begin
               chk($sformatf("wr_axi_data[%0d]", c), wr_axi_data[c], m_wq[c][0].d);
               chk($sformatf("wr_axi_last[%0d]", c), wr_axi_last[c], m_wq[c][0].last);
            end
            // read path update
            fire = m_full[c] && rd_fill_ready[c];
            acc  = rd_axi_v[c] && e_rrdy;
            if (fire) m_full[c] = 0;
            if (err_clr[c]) m_err[c] = 0;
            if (acc) begin
               m_beats[c].push_back(rd_axi_data[c]);
               if (m_beats[c].size() == R || rd_axi_last[c]) begin
                  w = '0;
                  for (int k = 0; k < m_beats[c].size(); k++)
                     w = w | (FW'(m_beats[c][k]) << (k*AW));
                  m_word[c] = w;
                  m_full[c] = 1;
                  if (m_beats[c].size() != R || !rd_axi_last[c]) m_err[c] = 1;
                  m_beats[c].delete();
               end
            end
            // write path update
            bacc = (m_wq[c].size() > 0) && wr_axi_ready[c];
            wacc = wr_fill_v[c] && e_wrdy;
            if (bacc) void'(m_wq[c].pop_front());
            if (wacc) begin
               for (int k = 0; k < R; k++) begin
                  b.d    = wr_fill_data[c][k*AW +: AW];
                  b.last = (k == R-1);
                  m_wq[c].push_back(b);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_beat(input int c, input logic [AW-1:0] d, input bit last);
      bit got;
      got = 0;
      rd_axi_v[c]    = 1'b1;
      rd_axi_data[c] = d;
      rd_axi_last[c] = last;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = rd_axi_ready[c];
         tick();
      end
      rd_axi_v[c]    = 1'b0;
      rd_axi_last[c] = 1'b0;
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL rd_beat_timeout ch%0d: beat %0h never accepted, required accept within 50 cycles", c, d);
      end
   endtask

   initial begin
      reset_n       = 1'b1;
      rd_axi_data   = '0;
      rd_axi_last   = '0;
      rd_axi_v      = '0;
      rd_fill_ready = '1;
      wr_fill_data  = '0;
      wr_fill_v     = '0;
      wr_axi_ready  = '1;
      err_clr       = '0;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready_lit", {wr_fill_ready, rd_axi_ready}, 0);
      chk("rst_valid_lit", {wr_axi_v, rd_fill_v}, 0);
      tick();
      reset_n       = 1'b1;
      rd_fill_ready = '0;
      tick();

      // basic 4-beat burst, held under backpressure
      rd_beat(0, 64'h11, 0);
      rd_beat(0, 64'h22, 0);
      rd_beat(0, 64'h33, 0);
      rd_beat(0, 64'h44, 1);
      @(negedge clk);
      chk("t1_word", rd_fill_data[0], {64'h44, 64'h33, 64'h22, 64'h11});
      chk("t1_v", rd_fill_v[0], 1);
      chk("t1_err", rd_err[0], 0);
      chk("bp_rd_ready", rd_axi_ready[0], 0);
      repeat (2) @(negedge clk);
      chk("bp_hold", rd_fill_data[0], {64'h44, 64'h33, 64'h22, 64'h11});
      tick();

      // flow-through: consume and accept beat 0 in the same cycle
      rd_fill_ready[0] = 1'b1;
      rd_axi_v[0]      = 1'b1;
      rd_axi_data[0]   = 64'h55;
      @(negedge clk);
      chk("ft_ready", rd_axi_ready[0], 1);
      tick();
      rd_axi_v[0]      = 1'b0;
      @(negedge clk);
      chk("ft_consumed", rd_fill_v[0], 0);
      tick();
      rd_fill_ready[0] = 1'b0;
      rd_beat(0, 64'h66, 0);
      rd_beat(0, 64'h77, 0);
      rd_beat(0, 64'h88, 1);
      @(negedge clk);
      chk("ft_word", rd_fill_data[0], {64'h88, 64'h77, 64'h66, 64'h55});
      tick();

      // short burst: zero padding and sticky error
      rd_fill_ready[0] = 1'b1;
      rd_beat(0, 64'hAA, 0);
      rd_fill_ready[0] = 1'b0;
      rd_beat(0, 64'hBB, 1);
      @(negedge clk);
      chk("short_word", rd_fill_data[0], {64'h0, 64'h0, 64'hBB, 64'hAA});
      chk("short_err", rd_err[0], 1);
      tick();
      err_clr[0] = 1'b1;
      tick();
      err_clr[0] = 1'b0;
      @(negedge clk);
      chk("err_cleared", rd_err[0], 0);
      tick();
      rd_fill_ready[0] = 1'b1;
      tick();

      // long burst: no last on beat R-1
      rd_beat(0, 64'h1, 0);
      rd_beat(0, 64'h2, 0);
      rd_beat(0, 64'h3, 0);
      rd_beat(0, 64'h4, 0);
      @(negedge clk);
      chk("long_word", rd_fill_data[0], {64'h4, 64'h3, 64'h2, 64'h1});
      chk("long_err", rd_err[0], 1);
      tick();
      err_clr[0] = 1'b1;
      rd_beat(0, 64'h9, 1);
      err_clr[0] = 1'b0;
      @(negedge clk);
      chk("set_wins", rd_err[0], 1);
      tick();
      err_clr[0] = 1'b1;
      tick();
      err_clr[0] = 1'b0;
      tick();

      // write path: back-to-back words with no bubble
      wr_fill_v[0]    = 1'b1;
      wr_fill_data[0] = {64'h4, 64'h3, 64'h2, 64'h1};
      @(negedge clk);
      chk("wr_idle_ready", wr_fill_ready[0], 1);
      tick();
      wr_fill_v[0] = 1'b0;
      @(negedge clk);
      chk("wr_b1", {wr_axi_v[0], wr_axi_last[0], wr_axi_data[0]}, {1'b1, 1'b0, 64'h1});
      tick();
      tick();
      tick();
      wr_fill_v[0]    = 1'b1;
      wr_fill_data[0] = {64'h8, 64'h7, 64'h6, 64'h5};
      @(negedge clk);
      chk("wr_b4", {wr_axi_v[0], wr_axi_last[0], wr_axi_data[0]}, {1'b1, 1'b1, 64'h4});
      chk("wr_b4_fill_ready", wr_fill_ready[0], 1);
      tick();
      wr_fill_v[0] = 1'b0;
      @(negedge clk);
      chk("wr_nobubble", {wr_axi_v[0], wr_axi_last[0], wr_axi_data[0]}, {1'b1, 1'b0, 64'h5});
      repeat (5) tick();

      // channel independence: ch1 write stalled while ch0 reads
      wr_axi_ready[1] = 1'b0;
      wr_fill_v[1]    = 1'b1;
      wr_fill_data[1] = {64'hD, 64'hC, 64'hB, 64'hA};
      @(negedge clk);
      chk("ch1_idle_ready", wr_fill_ready[1], 1);
      tick();
      wr_fill_v[1]     = 1'b0;
      rd_fill_ready[0] = 1'b0;
      rd_beat(0, 64'h101, 0);
      rd_beat(0, 64'h202, 0);
      rd_beat(0, 64'h303, 0);
      rd_beat(0, 64'h404, 1);
      @(negedge clk);
      chk("ind_ch0_word", rd_fill_data[0], {64'h404, 64'h303, 64'h202, 64'h101});
      chk("ind_ch1_held", {wr_axi_v[1], wr_axi_data[1]}, {1'b1, 64'hA});
      chk("ind_ch1_fill_ready", wr_fill_ready[1], 0);
      tick();
      wr_axi_ready[1]  = 1'b1;
      rd_fill_ready[0] = 1'b1;
      repeat (6) tick();

      // reset mid-burst discards the partial word
      rd_fill_ready[0] = 1'b0;
      rd_beat(0, 64'hE1, 0);
      rd_beat(0, 64'hE2, 0);
      reset_n = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_rst_valid", {wr_axi_v, rd_fill_v}, 0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", {wr_axi_v, rd_fill_v}, 0);
      tick();
      rd_beat(0, 64'hF1, 0);
      rd_beat(0, 64'hF2, 0);
      rd_beat(0, 64'hF3, 0);
      rd_beat(0, 64'hF4, 1);
      @(negedge clk);
      chk("post_rst_word", rd_fill_data[0], {64'hF4, 64'hF3, 64'hF2, 64'hF1});
      chk("post_rst_err", rd_err[0], 0);
      tick();
      rd_fill_ready[0] = 1'b1;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
